// File: rtl/alu_seq_ctrl.sv
// Sequencer that owns the shared combinational ALU: accepts one instruction at a time,
// iterates it 1..16 times through a small register file, then pulses done.
module alu_seq_ctrl #(
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [3:0]    i_op,
  input  logic [AW-1:0] i_rd,
  input  logic [AW-1:0] i_rs1,
  input  logic [AW-1:0] i_rs2,
  input  logic [3:0]    i_rep,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [3:0]    alu_ctrl,
  output logic [DW-1:0] alu_x,
  output logic [DW-1:0] alu_y,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  output logic          carry_flag,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_regs [NREG];
  logic [3:0]    r_op;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_rs1;
  logic [AW-1:0] r_rs2;
  logic [3:0]    r_cnt;
  logic          r_iter0;
  logic          w_accept;

  assign rd_data  = r_regs[rd_addr];
  assign w_accept = i_valid && i_ready;

  // Control FSM; busy/i_ready/done are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
      r_op       <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_cnt      <= '0;
      r_iter0    <= 1'b0;
      alu_ctrl   <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      carry_flag <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      i_ready    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Host write lands on this edge, so an instruction accepted now reads it in FETCH.
          if (wr_en) r_regs[wr_addr] <= wr_data;
          if (w_accept) begin
            r_op    <= i_op;
            r_rd    <= i_rd;
            r_rs1   <= i_rs1;
            r_rs2   <= i_rs2;
            r_cnt   <= i_rep;
            r_iter0 <= 1'b1;
            busy    <= 1'b1;
            i_ready <= 1'b0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          alu_ctrl <= r_op;
          alu_y    <= r_regs[r_rs2];
          alu_x    <= r_iter0 ? r_regs[r_rs1] : r_regs[r_rd];
          r_state  <= ST_EXEC;
        end
        ST_EXEC: begin
          r_regs[r_rd] <= alu_out;
          carry_flag   <= alu_carry;
          r_iter0      <= 1'b0;
          if (r_cnt == 4'd0) begin
            done    <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt   <= r_cnt - 4'd1;
            r_state <= ST_FETCH;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          i_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          i_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: behavioural ALU plus an instruction-level
// register-file model; directed cases followed by randomized instructions.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_valid;
  logic       i_ready;
  logic [3:0] i_op;
  logic [2:0] i_rd, i_rs1, i_rs2;
  logic [3:0] i_rep;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_x, alu_y, alu_out;
  logic       alu_carry;
  logic       carry_flag, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_regs [8];
  logic       m_carry;
  logic [7:0] exp_x [16];
  logic [7:0] exp_y [16];

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_op(i_op), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rep(i_rep),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .carry_flag(carry_flag), .busy(busy), .done(done)
  );

  // Behavioural ALU: 0 add, 1 sub (borrow), 2 and, 3 or, 4 not, 5 xor, 6 shl; others scramble.
  function automatic logic [8:0] alu_f(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    case (c)
      4'h0:    return {1'b0, x} + {1'b0, y};
      4'h1:    return {1'b0, x} - {1'b0, y};
      4'h2:    return {1'b0, x & y};
      4'h3:    return {1'b0, x | y};
      4'h4:    return {1'b0, ~x};
      4'h5:    return {1'b0, x ^ y};
      4'h6:    return {x, 1'b0};
      default: return {1'b0, x ^ y ^ 8'h5A};
    endcase
  endfunction

  always_comb {alu_carry, alu_out} = alu_f(alu_ctrl, alu_x, alu_y);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      check(tag, {24'd0, rd_data}, {24'd0, m_regs[a]});
    end
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    m_regs[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Issue one instruction and follow it to completion, checking against the model.
  task automatic run_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic [3:0] rep,
                           input bit with_wr, input logic [2:0] waddr, input logic [7:0] wdata,
                           input bit hold);
    int lat, cyc, busy_cnt;
    bit got_done;
    logic [7:0] x, y, r1_before;
    logic [8:0] res;
    @(negedge clk);
    check("ready_idle", {31'd0, i_ready}, 32'd1);
    if (with_wr) m_regs[waddr] = wdata;
    for (int k = 0; k <= int'(rep); k++) begin
      x = (k == 0) ? m_regs[rs1] : m_regs[rd];
      y = m_regs[rs2];
      exp_x[k] = x; exp_y[k] = y;
      res = alu_f(op, x, y);
      m_regs[rd] = res[7:0];
      m_carry = res[8];
    end
    r1_before = m_regs[1];
    lat = 2 * (int'(rep) + 1) + 1;
    i_valid = 1'b1; i_op = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_rep = rep;
    wr_en = with_wr; wr_addr = waddr; wr_data = wdata;
    @(posedge clk);
    got_done = 1'b0; busy_cnt = 0; cyc = 0;
    while (!got_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if (!hold) i_valid = 1'b0;
        wr_en = 1'b0;
      end
      if (hold && cyc == 2) begin
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = ~r1_before;
      end
      if (hold && cyc == 3) wr_en = 1'b0;
      if (busy) busy_cnt++;
      check("ready_busy", {31'd0, i_ready}, 32'd0);
      if (cyc % 2 == 0 && cyc < lat) begin
        check("alu_x", {24'd0, alu_x}, {24'd0, exp_x[cyc/2-1]});
        check("alu_y", {24'd0, alu_y}, {24'd0, exp_y[cyc/2-1]});
        check("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, op});
      end
      if (done) begin
        got_done = 1'b1;
        i_valid = 1'b0;
        check("done_latency", cyc, lat);
      end
    end
    if (!got_done) check("done_timeout", 32'd0, 32'd1);
    check("busy_cycles", busy_cnt, lat);
    check("carry_flag", {31'd0, carry_flag}, {31'd0, m_carry});
    check_regs("regfile");
    @(negedge clk);
    check("ready_after", {31'd0, i_ready}, 32'd1);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, {31'd0, i_ready}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_carry"}, {31'd0, carry_flag}, 32'd0);
    check({tag, "_alu"}, {4'd0, alu_ctrl, alu_x, alu_y}, 32'd0);
    check_regs({tag, "_regs"});
  endtask

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_op = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0; i_rep = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int a = 0; a < 8; a++) m_regs[a] = 8'h00;
    m_carry = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset");

    // NOT of a host-written value, single iteration
    host_write(3'd1, 8'h0F);
    run_instr(4'b0100, 3'd2, 3'd1, 3'd0, 4'd0, 1'b0, 3'd0, 8'd0, 1'b0);
    // Repeated add accumulates into rd
    host_write(3'd1, 8'd5);
    host_write(3'd3, 8'd3);
    run_instr(4'b0000, 3'd4, 3'd1, 3'd3, 4'd2, 1'b0, 3'd0, 8'd0, 1'b0);
    check("acc_result", {24'd0, m_regs[4]}, 32'd14);
    // Add overflow sets carry
    host_write(3'd1, 8'hFF);
    host_write(3'd3, 8'h01);
    run_instr(4'b0000, 3'd4, 3'd1, 3'd3, 4'd0, 1'b0, 3'd0, 8'd0, 1'b0);
    check("ovf_carry", {31'd0, carry_flag}, 32'd1);
    // Valid held while busy, host write during EXEC ignored
    run_instr(4'b0000, 3'd5, 3'd3, 3'd3, 4'd1, 1'b0, 3'd0, 8'd0, 1'b1);
    // rd==rs2 with repeats, same-cycle write with accept, 16 iterations
    run_instr(4'b0000, 3'd3, 3'd1, 3'd3, 4'd3, 1'b1, 3'd1, 8'h21, 1'b0);
    run_instr(4'b0001, 3'd6, 3'd6, 3'd2, 4'hF, 1'b0, 3'd0, 8'd0, 1'b0);

    // Reset during the second EXEC aborts the instruction
    host_write(3'd1, 8'h10);
    @(negedge clk);
    i_valid = 1'b1; i_op = 4'b0000; i_rd = 3'd2; i_rs1 = 3'd1; i_rs2 = 3'd1; i_rep = 4'd3;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) i_valid = 1'b0;
      check("abort_nodone", {31'd0, done}, 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) m_regs[a] = 8'h00;
    m_carry = 1'b0;
    check_reset_state("abort");
    @(negedge clk);
    check("abort_done_late", {31'd0, done}, 32'd0);

    // Randomized instructions
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) host_write(3'($urandom_range(0, 7)), 8'($urandom));
      run_instr(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
